// File: rtl/cfu_input_sequencer.sv
// Command-driven drain controller for the CFU input word FIFO: pops cmd_len prefetched
// words, unpacks each into four offset-adjusted signed int8 lanes and streams them out.
module cfu_input_sequencer #(
    parameter int LEN_W   = 9,
    parameter int STALL_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_start,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic signed [8:0]         cmd_offset,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      buf_read_en,
    input  logic [31:0]               buf_read_data,
    input  logic                      buf_empty,
    output logic                      buf_clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [39:0]               out_data,
    output logic                      out_last,
    output logic [LEN_W-1:0]          words_left,
    output logic [STALL_W-1:0]        stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic signed [8:0]  offset_q;
    logic               accept;
    logic               pop;
    logic               stall_inc;

    // Byte sign-extended to 10 bits plus offset sign-extended to 10 bits; range fits exactly.
    function automatic logic signed [9:0] lane_sum(input logic [7:0] b,
                                                   input logic signed [8:0] off);
        logic signed [9:0] bx;
        logic signed [9:0] ox;
        bx = {{2{b[7]}}, b};
        ox = {off[8], off};
        return bx + ox;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        buf_read_en = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        accept      = 1'b0;
        pop         = 1'b0;
        stall_inc   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_len == '0) ? S_DONE : S_PRIME;
                end
            end
            // Head register settles one cycle after any pointer move, so data is never used here.
            S_PRIME: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!buf_empty) begin
                    state_nxt = S_PRESENT;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            S_PRESENT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (words_left == LEN_ONE);
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (out_ready) begin
                    buf_read_en = 1'b1;
                    pop         = 1'b1;
                    state_nxt   = (words_left == LEN_ONE) ? S_DONE : S_PRIME;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = !abort;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Clear is withheld while reset is asserted so a reset never disturbs the FIFO.
    assign buf_clear = abort && rst;

    always_comb begin
        out_data = '0;
        if (state == S_PRESENT) begin
            for (int i = 0; i < 4; i++) begin
                out_data[10*i +: 10] = lane_sum(buf_read_data[8*i +: 8], offset_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset_q     <= '0;
            words_left   <= '0;
            stall_cycles <= '0;
        end else if (accept) begin
            offset_q     <= cmd_offset;
            words_left   <= cmd_len;
            stall_cycles <= '0;
        end else if (abort) begin
            words_left   <= '0;
        end else begin
            if (pop) begin
                words_left <= words_left - LEN_ONE;
            end
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cfu_input_sequencer.sv
// Scoreboard bench for cfu_input_sequencer: a prefetching FIFO model feeds the DUT, a monitor
// pops hand-computed lane words from a queue on every accepted transfer.
module tb_cfu_input_sequencer;

    localparam int LEN_W   = 9;
    localparam int STALL_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cmd_start = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic signed [8:0]  cmd_offset = '0;
    logic               abort = 1'b0;
    logic               busy;
    logic               done;
    logic               buf_read_en;
    logic [31:0]        buf_read_data = 32'h0;
    logic               buf_empty = 1'b1;
    logic               buf_clear;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [39:0]        out_data;
    logic               out_last;
    logic [LEN_W-1:0]   words_left;
    logic [STALL_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    cfu_input_sequencer #(.LEN_W(LEN_W), .STALL_W(STALL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_start    (cmd_start),
        .cmd_len      (cmd_len),
        .cmd_offset   (cmd_offset),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .buf_read_en  (buf_read_en),
        .buf_read_data(buf_read_data),
        .buf_empty    (buf_empty),
        .buf_clear    (buf_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .words_left   (words_left),
        .stall_cycles (stall_cycles)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int pop_empty_err = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int clear_cnt = 0;
    int hold_chk = 0;

    logic [31:0] fifo_q[$];
    logic        push_req = 1'b0;
    logic [31:0] push_data = 32'h0;
    logic [40:0] exp_q[$];
    int          xfer_cyc[$];
    int          xfer_wl[$];
    logic        held = 1'b0;
    logic [40:0] held_val = '0;
    logic [40:0] e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] expw(input logic last, input int l3, input int l2,
                                         input int l1, input int l0);
        logic [40:0] r;
        r = {last, l3[9:0], l2[9:0], l1[9:0], l0[9:0]};
        return r;
    endfunction

    // Prefetching FIFO: head/empty update one cycle after a push or pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (buf_clear) begin
                fifo_q.delete();
            end else if (buf_read_en) begin
                pop_cnt++;
                if (fifo_q.size() == 0) pop_empty_err++;
                else fifo_q.delete(0);
            end
            if (push_req) fifo_q.push_back(push_data);
        end
        buf_empty     <= (fifo_q.size() == 0);
        buf_read_data <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (held && out_valid && !abort) begin
                hold_chk++;
                chk("hold_stable", {23'h0, out_last, out_data}, {23'h0, held_val});
            end
            held     = out_valid && !out_ready && !abort;
            held_val = {out_last, out_data};
            if (out_valid && out_ready && !abort) begin
                xfer_cyc.push_back(cyc);
                xfer_wl.push_back(int'(words_left));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("lane_word", {23'h0, out_last, out_data}, {23'h0, e});
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (buf_clear) clear_cnt++;
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        push_req  = 1'b1;
        push_data = w;
        tick();
        push_req  = 1'b0;
    endtask

    task automatic start_cmd(input int len, input int off);
        cmd_start  = 1'b1;
        cmd_len    = len[LEN_W-1:0];
        cmd_offset = off[8:0];
        tick();
        cmd_start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int p0;
        int x0;
        int c0;

        // reset state, with abort held high to show no clear leaks out during reset
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {busy, done, buf_read_en, buf_clear, out_valid, out_last}, 0);
        chk("reset_data", out_data, 0);
        chk("reset_cnt", {words_left, stall_cycles}, 0);
        abort = 1'b0;
        rst   = 1'b1;
        tick();

        // 1: two prefilled words, offset +128
        push_word(32'h7F80_01FF);
        push_word(32'h0000_0080);
        exp_q.push_back(expw(1'b0, 255, 0, 129, 127));
        exp_q.push_back(expw(1'b1, 128, 128, 128, 0));
        out_ready = 1'b1;
        d0 = done_cnt; p0 = pop_cnt; x0 = xfer_cyc.size();
        start_cmd(2, 128);
        chk("t1_busy_after_accept", busy, 1);
        wait_done(d0, 50);
        chk("t1_xfers", xfer_cyc.size() - x0, 2);
        if (xfer_cyc.size() - x0 == 2) begin
            chk("t1_word_gap", xfer_cyc[x0+1] - xfer_cyc[x0], 2);
            chk("t1_done_latency", done_cyc - xfer_cyc[x0+1], 1);
        end
        chk("t1_pops", pop_cnt - p0, 2);
        chk("t1_stall", stall_cycles, 0);
        chk("t1_idle", busy, 0);

        // 2: empty FIFO, one word every 5 cycles, offset 0
        exp_q.push_back(expw(1'b0, 1, 2, 3, 4));
        exp_q.push_back(expw(1'b0, -1, -2, -3, -128));
        exp_q.push_back(expw(1'b1, 127, 0, 0, -128));
        d0 = done_cnt; p0 = pop_cnt; x0 = xfer_cyc.size();
        start_cmd(3, 0);
        repeat (4) tick();
        push_word(32'h0102_0304);
        repeat (4) tick();
        push_word(32'hFFFE_FD80);
        repeat (4) tick();
        push_word(32'h7F00_0080);
        wait_done(d0, 50);
        chk("t2_stall_cycles", stall_cycles, 11);
        chk("t2_pops", pop_cnt - p0, 3);
        chk("t2_xfers", xfer_cyc.size() - x0, 3);
        if (xfer_cyc.size() - x0 == 3) begin
            chk("t2_gap0", xfer_cyc[x0+1] - xfer_cyc[x0], 5);
            chk("t2_gap1", xfer_cyc[x0+2] - xfer_cyc[x0+1], 5);
        end

        // 3: len=4, offset -1, out_ready pattern 1,0,0
        push_word(32'h0000_0000);
        push_word(32'h7F7F_7F7F);
        push_word(32'h8080_8080);
        push_word(32'h01FF_0280);
        exp_q.push_back(expw(1'b0, -1, -1, -1, -1));
        exp_q.push_back(expw(1'b0, 126, 126, 126, 126));
        exp_q.push_back(expw(1'b0, -129, -129, -129, -129));
        exp_q.push_back(expw(1'b1, 0, -2, 1, -129));
        out_ready = 1'b0;
        d0 = done_cnt; p0 = pop_cnt; x0 = xfer_wl.size(); c0 = hold_chk;
        start_cmd(4, -1);
        chk("t3_stall_cleared", stall_cycles, 0);
        for (int k = 0; k < 60 && done_cnt == d0; k++) begin
            out_ready = (k % 3 == 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_pops", pop_cnt - p0, 4);
        chk("t3_xfers", xfer_wl.size() - x0, 4);
        if (xfer_wl.size() - x0 == 4) begin
            for (int k = 0; k < 4; k++) chk("t3_words_left_seq", xfer_wl[x0+k], 4 - k);
        end
        chk("t3_words_left_end", words_left, 0);
        chk("t3_hold_seen", hold_chk > c0, 1);

        // 4: zero-length command
        d0 = done_cnt; p0 = pop_cnt;
        start_cmd(0, 0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        tick();
        chk("t4_done_after", {busy, done}, 0);
        chk("t4_no_pop", pop_cnt - p0, 0);
        chk("t4_done_count", done_cnt - d0, 1);

        // 5: abort in PRESENT with out_ready=1; cmd_start mid-command ignored
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        out_ready = 1'b0;
        d0 = done_cnt; c0 = clear_cnt;
        start_cmd(2, 0);
        tick();
        chk("t5_present", out_valid, 1);
        cmd_start = 1'b1;
        cmd_len   = 9'd7;
        tick();
        cmd_start = 1'b0;
        chk("t5_start_ignored", words_left, 2);
        p0 = pop_cnt;
        abort     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t5_abort_clear", buf_clear, 1);
        chk("t5_abort_no_pop", buf_read_en, 0);
        tick();
        abort = 1'b0;
        chk("t5_idle", {busy, out_valid}, 0);
        chk("t5_words_left", words_left, 0);
        tick();
        tick();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_pop", pop_cnt - p0, 0);
        chk("t5_clears", clear_cnt - c0, 1);

        // abort together with cmd_start in IDLE: abort wins
        abort     = 1'b1;
        cmd_start = 1'b1;
        cmd_len   = 9'd3;
        #1;
        chk("idle_abort_clear", buf_clear, 1);
        tick();
        abort     = 1'b0;
        cmd_start = 1'b0;
        chk("idle_abort_no_start", {busy, words_left}, 0);

        // 6: reset mid-command, then a clean len=1 command with offset -256
        out_ready = 1'b1;
        start_cmd(5, 0);
        tick();
        chk("t6_in_prime", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_ctl", {busy, done, buf_read_en, buf_clear, out_valid, out_last}, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_cnt", {words_left, stall_cycles}, 0);
        tick();
        rst = 1'b1;
        tick();
        push_word(32'h0000_0080);
        exp_q.push_back(expw(1'b1, -256, -256, -256, -384));
        d0 = done_cnt; p0 = pop_cnt;
        start_cmd(1, -256);
        wait_done(d0, 50);
        chk("t6_pops", pop_cnt - p0, 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("never_pop_empty", pop_empty_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
